// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory fetch block.
package imem_pkg;

  typedef enum logic {S_INIT, S_RUN} state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;
  localparam int          PAR_MAX_W        = 1024;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  // Even parity bit: makes the total count of ones (word + bit) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_rsp_reg.sv
// Fetch response register: accepts a read result when the slot is free or
// being drained, holds it stable under back-pressure.
module imem_rsp_reg
  import imem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_done,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             req_accept,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             rd_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic             rsp_err_q,   rsp_err_d;

  assign req_ready  = init_done & (!rsp_valid_q | rsp_ready);
  assign req_accept = req_valid & req_ready;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (req_accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rd_data;
      rsp_err_d   = rd_err;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: rtl/imem_fetch.sv
// Handshaked instruction memory with post-reset clear sweep, registered fetch
// port and byte-enabled loader port. Define IMEM_PARITY_EN for per-word parity.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int               DEPTH    = 256,
  parameter int               WIDTH    = 32,
  parameter int               ADDR_W   = 32,
  parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(NOP_WORD_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               init_done,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
`ifdef IMEM_PARITY_EN
  output logic               parity_err,
  input  logic               par_inject,
`endif
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be
);

  localparam int              IDX_W     = idx_width(DEPTH);
  localparam int              BE_W      = WIDTH / 8;
  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [WIDTH-1:0] mem_wdata;

  logic [IDX_W-1:0] wr_idx, req_idx;
  logic             wr_fire, req_bad, req_accept;
  logic [WIDTH-1:0] wr_merged, rd_word, rd_data;
  logic             rd_err;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = S_RUN;
      end
      S_RUN: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_done = (state_q == S_RUN);
  assign wr_ready  = init_done;

  assign wr_idx  = wr_addr[IDX_W+1:2];
  assign wr_fire = wr_valid & wr_ready & ((wr_addr >> 2) < DEPTH_LIM);

  always_comb begin
    wr_merged = mem_q[wr_idx];
    for (int k = 0; k < BE_W; k++) begin
      if (wr_be[k]) wr_merged[8*k +: 8] = wr_data[8*k +: 8];
    end
  end

  // Single write port shared by the clear sweep and the loader.
  assign mem_we    = (state_q == S_INIT) | wr_fire;
  assign mem_idx   = (state_q == S_INIT) ? cnt_q : wr_idx;
  assign mem_wdata = (state_q == S_INIT) ? NOP_WORD : wr_merged;

  // NOTE: the array has no reset; the post-reset sweep clears it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_wdata;
  end

  // Read happens before the same-edge write lands, giving read-first behaviour.
  assign req_idx = req_addr[IDX_W+1:2];
  assign req_bad = (req_addr[1:0] != 2'b00) | ((req_addr >> 2) >= DEPTH_LIM);
  assign rd_word = mem_q[req_idx];

`ifdef IMEM_PARITY_EN
  logic mem_par_q [DEPTH];
  logic mem_par_wdata, par_mismatch;
  logic parity_err_q, parity_err_d;

  assign mem_par_wdata = even_parity(PAR_MAX_W'(mem_wdata)) ^ (wr_fire & par_inject);
  assign par_mismatch  = even_parity(PAR_MAX_W'(rd_word)) != mem_par_q[req_idx];
  assign rd_err        = req_bad | par_mismatch;
  assign parity_err_d  = parity_err_q | (req_accept & !req_bad & par_mismatch);

  always_ff @(posedge clk) begin
    if (mem_we) mem_par_q[mem_idx] <= mem_par_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign rd_err = req_bad;
`endif

  assign rd_data = rd_err ? NOP_WORD : rd_word;

  imem_rsp_reg #(.WIDTH(WIDTH)) u_rsp_reg (
    .clk        (clk),
    .reset      (reset),
    .init_done  (init_done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_accept (req_accept),
    .rd_data    (rd_data),
    .rd_err     (rd_err),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

endmodule

// File: tb/tb_imem_fetch.sv
// Directed self-checking bench for imem_fetch (DEPTH=256, WIDTH=32).
module tb_imem_fetch;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_done;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_be;
`ifdef IMEM_PARITY_EN
  logic        parity_err;
  logic        par_inject;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_fetch #(.DEPTH(DEPTH), .WIDTH(32), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
`ifdef IMEM_PARITY_EN
    .parity_err(parity_err),
    .par_inject(par_inject),
`endif
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 1000) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(DEPTH));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
`ifdef IMEM_PARITY_EN
    par_inject = 1'b0;
`endif
    repeat (3) tick();

    check("rst_outs", {58'd0, init_done, req_ready, wr_ready, rsp_valid, rsp_err, 1'b0}, 64'd0);
    check("rst_data", 64'(rsp_data), 64'd0);
`ifdef IMEM_PARITY_EN
    check("rst_parity_err", 64'(parity_err), 64'd0);
`endif

    reset = 1'b1;
    wait_init("init_cycles");
    check("readies_run", {62'd0, req_ready, wr_ready}, 64'd3);

    // Fetch every word back-to-back: all cleared to the NOP word.
    for (int i = 0; i < DEPTH; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      tick();
      check($sformatf("sweep_%0d", i), {30'd0, rsp_valid, rsp_err, rsp_data}, {30'd0, 1'b1, 1'b0, NOP});
    end
    req_valid = 1'b0;
    tick();
    check("rsp_drain", 64'(rsp_valid), 64'd0);

    // Byte-enable merge.
    do_write(32'h10, 32'hDEAD_BEEF, 4'b1111);
    do_write(32'h10, 32'h0000_00AA, 4'b0001);
    fetch(32'h10);
    check("merge", {31'd0, rsp_valid, rsp_err, rsp_data}, {31'd0, 1'b1, 1'b0, 32'hDEAD_BEAA});

    // Misaligned then out-of-range, back-to-back.
    req_valid = 1'b1; req_addr = 32'h12;
    tick();
    check("misalign", {31'd0, rsp_valid, rsp_err, rsp_data}, {31'd0, 1'b1, 1'b1, NOP});
    req_addr = 32'h400;
    tick();
    check("oor_fetch", {31'd0, rsp_valid, rsp_err, rsp_data}, {31'd0, 1'b1, 1'b1, NOP});
    req_valid = 1'b0;
    tick();

    // Out-of-range write must not alias onto index 0.
    do_write(32'h400, 32'hBAD0_BAD0, 4'b1111);
    fetch(32'h0);
    check("oor_write", {31'd0, rsp_valid, rsp_err, rsp_data}, {31'd0, 1'b1, 1'b0, NOP});

    // Same-cycle fetch and write to one index: read-first.
    req_valid = 1'b1; req_addr = 32'h20;
    wr_valid = 1'b1; wr_addr = 32'h20; wr_data = 32'h1234_5678; wr_be = 4'b1111;
    tick();
    req_valid = 1'b0; wr_valid = 1'b0;
    check("rdfirst_old", {31'd0, rsp_err, rsp_data}, {31'd0, 1'b0, NOP});
    fetch(32'h20);
    check("rdfirst_new", {31'd0, rsp_err, rsp_data}, {31'd0, 1'b0, 32'h1234_5678});

    // Back-pressure: hold 3 cycles, then stream with none lost or duplicated.
    for (int k = 0; k < 4; k++) do_write(32'(32'h40 + 4 * k), 32'(32'h1111_0000 + k), 4'b1111);
    tick();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h40;
    #1 check("bp_ready_idle", 64'(req_ready), 64'd1);
    tick();
    req_addr = 32'h44;
    for (int h = 0; h < 3; h++) begin
      #1;
      check($sformatf("bp_hold_ready_%0d", h), 64'(req_ready), 64'd0);
      check($sformatf("bp_hold_data_%0d", h), {31'd0, rsp_valid, rsp_data}, {31'd0, 1'b1, 32'h1111_0000});
      tick();
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", 64'(req_ready), 64'd1);
    for (int k = 1; k < 4; k++) begin
      req_addr = 32'(32'h40 + 4 * k);
      tick();
      check($sformatf("bp_stream_%0d", k), {31'd0, rsp_valid, rsp_data}, {31'd0, 1'b1, 32'(32'h1111_0000 + k)});
    end
    req_valid = 1'b0;
    tick();
    check("bp_end", 64'(rsp_valid), 64'd0);

`ifdef IMEM_PARITY_EN
    par_inject = 1'b1;
    do_write(32'h8, 32'hCAFE_F00D, 4'b1111);
    par_inject = 1'b0;
    fetch(32'h8);
    check("par_bad", {30'd0, rsp_err, parity_err, rsp_data}, {30'd0, 1'b1, 1'b1, NOP});
    fetch(32'h0);
    check("par_sticky", {30'd0, rsp_err, parity_err, rsp_data}, {30'd0, 1'b0, 1'b1, NOP});
    do_write(32'h8, 32'hCAFE_F00D, 4'b1111);
    fetch(32'h8);
    check("par_fixed", {30'd0, rsp_err, parity_err, rsp_data}, {30'd0, 1'b0, 1'b1, 32'hCAFE_F00D});
`endif

    // Reset in the middle of the sweep restarts it from zero.
    reset = 1'b0;
    tick();
    check("rst2_outs", {60'd0, init_done, req_ready, wr_ready, rsp_valid}, 64'd0);
    reset = 1'b1;
    repeat (100) tick();
    check("mid_sweep", 64'(init_done), 64'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wait_init("init_restart");
`ifdef IMEM_PARITY_EN
    check("par_cleared", 64'(parity_err), 64'd0);
`endif
    fetch(32'h10);
    check("cleared_again", {31'd0, rsp_valid, rsp_err, rsp_data}, {31'd0, 1'b1, 1'b0, NOP});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised, handshaked instruction memory for the pipeline fetch stage, replacing the single-port combinational-read instruction array. A hardware init sweep clears the array after reset. A registered fetch port uses valid/ready flow control and reports alignment and range errors. A byte-enabled loader write port is used by the boot/debug path.

## Interface
- DEPTH, 256: number of words; power of two, ≥4.
- WIDTH, 32: word width in bits; multiple of 8.
- ADDR_W, 32: byte-address width of both ports.
- NOP_WORD, 32'h0000_0013: init fill value; also returned as data on errored fetches.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low.
- init_done  out  1  array sweep finished; ports usable.
- req_valid  in  1  fetch request.
- req_ready  out  1  fetch accepted when valid&ready.
- req_addr  in  ADDR_W  fetch byte address.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_data  out  WIDTH  fetched word.
- rsp_err  out  1  response is errored (misaligned, out of range, parity).
- wr_valid  in  1  loader write request.
- wr_ready  out  1  write accepted when valid&ready.
- wr_addr  in  ADDR_W  write byte address; bits [1:0] ignored.
- wr_data  in  WIDTH  write data.
- wr_be  in  WIDTH/8  byte enables; bit k covers wr_data[8k+7:8k].

## Operation
- Word index: addr[$clog2(DEPTH)+1:2]. An address is out of range when addr>>2 ≥ DEPTH.
- FSM states:
  - INIT (entered on reset): writes NOP_WORD to index cnt; cnt increments 0..DEPTH-1. After the last word, moves to RUN.
  - RUN: terminal state until the next reset.
- A reset mid-sweep restarts at cnt=0.
- req_ready = init_done & (!rsp_valid | rsp_ready).
- wr_ready = init_done.
- In INIT both readies are 0, and requests and writes are ignored.
- Accepted fetch:
  - If req_addr[1:0]≠0 or the address is out of range: next cycle rsp_err=1, rsp_data=NOP_WORD.
  - Otherwise: rsp_err=0, rsp_data=mem[index].
- Response hold: while rsp_valid & !rsp_ready, rsp_data and rsp_err are held stable. The array is not re-read.
- rsp_valid clears on rsp_ready with no new accept. Back-to-back accepts give one response per cycle.
- Accepted write: bytes with wr_be=1 are updated and the others are kept. Out-of-range writes are dropped silently.
- Same-cycle fetch and write to the same index: read-first. The response shows the old word; the new word is visible from the next accepted fetch.

## Timing
- Reset values: init_done=0, req_ready=0, wr_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
- init_done rises in the DEPTH-th clock after reset deasserts. It stays 1 until the next reset.
- Fetch latency: 1 cycle from the accepting edge to rsp_valid.
- Throughput: 1 fetch per cycle while rsp_ready=1.
- Write latency: the write commits at the accepting edge.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word stores one extra even-parity bit, computed over the merged word at write and at init.
  - Parity is checked on every in-range aligned fetch. A mismatch forces rsp_err=1 and rsp_data=NOP_WORD, and sets a sticky parity_err output (1 bit, reset 0).
  - Adds input par_inject (1 bit), which inverts the stored parity bit of the word written in that cycle.
- IMEM_PARITY_EN undefined: no parity storage, no parity_err, no par_inject. rsp_err reflects alignment and range only.

## Structure
- Package imem_pkg holds:
  - the FSM state enum {S_INIT, S_RUN};
  - the NOP_WORD default constant;
  - a function for the word-index width, $clog2(DEPTH);
  - a function for even parity.
- One sub-module, imem_rsp_reg: the output response register with hold/accept logic (rsp_valid, rsp_data, rsp_err, ready back-pressure).
- The array, init FSM and write merge stay in the top.

## Test plan
- Reset, then fetch every index → init_done rises after exactly 256 cycles; every word reads 0x0000_0013 with rsp_err=0.
- Write 0xDEADBEEF to 0x10 with be=4'b1111, then write 0x000000AA with be=4'b0001, then fetch 0x10 → rsp_data=0xDEADBEAA one cycle after accept.
- Fetch 0x12, then fetch 0x400 (DEPTH=256) → both give rsp_err=1 and rsp_data=0x0000_0013.
- Fetch 0x20 and write 0x12345678 to 0x20 in the same cycle → response shows the old word; the next fetch returns 0x12345678.
- Hold rsp_ready=0 for 3 cycles with req_valid=1 → req_ready=0 and rsp_data stable; on release, queued fetches stream at 1 per cycle with none lost or duplicated.
- With IMEM_PARITY_EN: write to 0x8 with par_inject=1, then fetch 0x8 → rsp_err=1 and parity_err=1, which stays set until reset. Assert reset during INIT at cnt=100 → sweep restarts and init_done takes a further 256 cycles.
